// File: rtl/prim_sky130_ram_1p_tiled.sv
// rtl/prim_sky130_ram_1p_tiled.sv - tiled single-port RAM over 32x512 sky130 SRAM macros
// Bit-granular write masks; partially-masked bytes go through a one-cycle read-modify-write.
package prim_ram_1p_pkg;
  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } ram_1p_cfg_t;
endpackage

module sky130_sram_2kbyte_1rw1r_32x512_8 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [8:0]  addr1,
  output logic [31:0] dout1
);
  logic [31:0] mem_q [512];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
        end
      end else begin
        dout0 <= mem_q[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem_q[addr1];
  end
endmodule

module prim_sky130_ram_1p_tiled
  import prim_ram_1p_pkg::*;
#(
  parameter int    Width           = 32,
  parameter int    Depth           = 512,
  parameter int    DataBitsPerMask = 1,
  parameter string MemInitFile     = "",
  localparam int   Aw              = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              write_i,
  input  logic [Aw-1:0]     addr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [Width-1:0]  wmask_i,
  output logic              rvalid_o,
  output logic [Width-1:0]  rdata_o,
  input  ram_1p_cfg_t       cfg_i
);
  localparam int NCol  = Width / 32;
  localparam int NBank = Depth / 512;
  localparam int NByte = Width / 8;
  localparam int BankW = (Aw > 9) ? Aw - 9 : 1;
  localparam logic [Aw:0] DepthL = (Aw+1)'(Depth);

  if (Width % 32 != 0 || Width == 0) begin : g_bad_width
    $error("Width must be a non-zero multiple of 32");
  end
  if (Depth % 512 != 0 || Depth == 0) begin : g_bad_depth
    $error("Depth must be a non-zero multiple of 512");
  end

  typedef enum logic {IDLE, RMW} state_e;

  state_e             state_q, state_d;
  logic               rvalid_q, rvalid_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic               range_q, range_d;
  logic [8:0]         row_q, row_d;
  logic [Width-1:0]   wdata_q, wdata_d;
  logic [Width-1:0]   wmask_q, wmask_d;

  logic [Aw:0]        addr_ext;
  logic [Aw:0]        bank_ext;
  logic [BankW-1:0]   bank_in;
  logic               in_range;
  logic [NByte-1:0]   byte_full, byte_any;
  logic               is_partial;

  logic [NBank-1:0]   m_csb;
  logic               m_web;
  logic [NByte-1:0]   m_bmask;
  logic [8:0]         m_row;
  logic [Width-1:0]   m_din;
  logic               sel_en;
  logic [BankW-1:0]   sel_bank;
  logic [Width-1:0]   bank_dout [NBank];
  logic [Width-1:0]   sel_dout;
  logic [31:0]        unused_dout1 [NBank][NCol];
  logic               unused_cfg;

  assign unused_cfg = ^cfg_i;
  assign addr_ext   = {1'b0, addr_i};
  assign bank_ext   = addr_ext >> 9;
  assign bank_in    = bank_ext[BankW-1:0];
  assign in_range   = addr_ext < DepthL;

  always_comb begin
    byte_full = '0;
    byte_any  = '0;
    for (int i = 0; i < NByte; i++) begin
      byte_full[i] = &wmask_i[8*i +: 8];
      byte_any[i]  = |wmask_i[8*i +: 8];
    end
  end
  assign is_partial = |(byte_any & ~byte_full);

  // bank_q always names the bank of the last accepted request: read mux and RMW source
  always_comb begin
    sel_dout = '0;
    for (int b = 0; b < NBank; b++) begin
      if (bank_q == BankW'(b)) sel_dout = bank_dout[b];
    end
  end

  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    bank_d   = bank_q;
    range_d  = range_q;
    row_d    = row_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    gnt_o    = 1'b0;
    m_web    = 1'b1;
    m_bmask  = byte_full;
    m_row    = addr_i[8:0];
    m_din    = wdata_i;
    sel_en   = 1'b0;
    sel_bank = bank_in;
    m_csb    = '1;
    if (rst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_o = 1'b1;
          if (req_i) begin
            bank_d  = bank_in;
            range_d = in_range;
            sel_en  = in_range;
            if (!write_i) begin
              rvalid_d = 1'b1;
            end else if (is_partial) begin
              state_d = RMW;
              row_d   = addr_i[8:0];
              wdata_d = wdata_i;
              wmask_d = wmask_i;
            end else begin
              m_web = 1'b0;
            end
          end
        end
        RMW: begin
          m_web    = 1'b0;
          m_row    = row_q;
          m_bmask  = '1;
          m_din    = (sel_dout & ~wmask_q) | (wdata_q & wmask_q);
          sel_en   = range_q;
          sel_bank = bank_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
      for (int b = 0; b < NBank; b++) begin
        if (sel_en && sel_bank == BankW'(b)) m_csb[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    bank_q  <= bank_d;
    range_q <= range_d;
    row_q   <= row_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (rvalid_q && range_q) ? sel_dout : '0;

  for (genvar b = 0; b < NBank; b++) begin : g_bank
    for (genvar c = 0; c < NCol; c++) begin : g_col
      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
        .clk0   (clk_i),
        .csb0   (m_csb[b]),
        .web0   (m_web),
        .wmask0 (m_bmask[4*c +: 4]),
        .addr0  (m_row),
        .din0   (m_din[32*c +: 32]),
        .dout0  (bank_dout[b][32*c +: 32]),
        .clk1   (clk_i),
        .csb1   (1'b1),
        .addr1  (9'd0),
        .dout1  (unused_dout1[b][c])
      );
    end
  end
endmodule

// File: tb/tb_prim_sky130_ram_1p_tiled.sv
// tb/tb_prim_sky130_ram_1p_tiled.sv - scoreboard bench for the tiled sky130 RAM
// Width=64, Depth=1536 covers bank tiling, partial writes and out-of-range addresses.
module tb_prim_sky130_ram_1p_tiled;
  import prim_ram_1p_pkg::*;

  localparam int W  = 64;
  localparam int D  = 1536;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic          write_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  wdata_i;
  logic [W-1:0]  wmask_i;
  logic          rvalid_o;
  logic [W-1:0]  rdata_o;
  ram_1p_cfg_t   cfg_i;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q [$];

  localparam logic [W-1:0] ONES = '1;

  always #5 clk = ~clk;

  prim_sky130_ram_1p_tiled #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .wmask_i  (wmask_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .cfg_i    (cfg_i)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_i && rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_rvalid: got rvalid_o=1 rdata 0x%h expected no response", rdata_o);
      end else begin
        check("rdata", rdata_o, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic cyc(input logic rq, input logic wr, input logic [AW-1:0] a,
                     input logic [W-1:0] wd, input logic [W-1:0] wm,
                     input logic exp_gnt, input logic [W-1:0] exp_rd);
    req_i   = rq;
    write_i = wr;
    addr_i  = a;
    wdata_i = wd;
    wmask_i = wm;
    #3;
    check("gnt", {{(W-1){1'b0}}, gnt_o}, {{(W-1){1'b0}}, exp_gnt});
    if (rq && !wr && exp_gnt) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    cyc(1'b1, 1'b1, a, d, m, 1'b1, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e);
    cyc(1'b1, 1'b0, a, '0, '0, 1'b1, e);
  endtask

  initial begin
    cfg_i   = '0;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    write_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    wmask_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #3;
    check("reset_gnt", {{(W-1){1'b0}}, gnt_o}, 64'd1);
    check("reset_rvalid", {{(W-1){1'b0}}, rvalid_o}, 64'd0);
    @(posedge clk);
    #1;

    // Bank 1 row 5 vs bank 0 row 5
    wr(11'h005, 64'hDEADBEEF00C0FFEE, ONES);
    wr(11'h205, 64'h1122334455667788, ONES);
    rd(11'h205, 64'h1122334455667788);
    rd(11'h005, 64'hDEADBEEF00C0FFEE);

    // Partial write: byte0 mask 0x0F, 0xDD -> 0xDF; a request during RMW is refused
    wr(11'h003, 64'h55555555AABBCCDD, ONES);
    wr(11'h003, 64'hFFFFFFFF0000000F, 64'h000000000000000F);
    cyc(1'b1, 1'b0, 11'h003, '0, '0, 1'b0, '0);
    rd(11'h003, 64'h55555555AABBCCDF);
    // Mixed full/empty bytes take the single-cycle path
    wr(11'h003, 64'h9999888877776666, 64'hFFFF0000FF000000);
    rd(11'h003, 64'h9999555577BBCCDF);
    wr(11'h003, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    rd(11'h003, 64'h9999555577BBCCDF);

    // Back-to-back reads across the bank 0/1 boundary
    wr(11'h000, 64'h0101010101010101, ONES);
    wr(11'h1FF, 64'h0202020202020202, ONES);
    wr(11'h200, 64'h0303030303030303, ONES);
    rd(11'h000, 64'h0101010101010101);
    rd(11'h1FF, 64'h0202020202020202);
    rd(11'h200, 64'h0303030303030303);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b1, '0);

    // Reset during RMW abandons the write
    wr(11'h007, 64'hCAFEBABE12345678, ONES);
    wr(11'h007, 64'h0, 64'h00000000000000F0);
    req_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    #3;
    check("rst_rmw_rvalid", {{(W-1){1'b0}}, rvalid_o}, 64'd0);
    @(posedge clk);
    #1;
    rd(11'h007, 64'hCAFEBABE12345678);

    // Out-of-range 0x700 (bank 3 of 3) selects nothing; aliases of row 0x100 stay intact
    wr(11'h100, 64'hA0A0A0A0A0A0A0A0, ONES);
    wr(11'h300, 64'hB1B1B1B1B1B1B1B1, ONES);
    wr(11'h500, 64'hC2C2C2C2C2C2C2C2, ONES);
    rd(11'h500, 64'hC2C2C2C2C2C2C2C2);
    rd(11'h700, 64'h0);
    wr(11'h700, ONES, ONES);
    rd(11'h700, 64'h0);
    rd(11'h100, 64'hA0A0A0A0A0A0A0A0);
    rd(11'h300, 64'hB1B1B1B1B1B1B1B1);
    rd(11'h500, 64'hC2C2C2C2C2C2C2C2);

    req_i = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/prim_sky130_ram_1p_tiled.md
Name: prim_sky130_ram_1p_tiled

Overview:
- Parametrised single-port RAM built from an array of sky130_sram_2kbyte_1rw1r_32x512_8 macros (32 bit x 512 word, byte write mask).
- Tiles macros in width (columns of 32 bits) and depth (banks of 512 words).
- Supports any bit-granular write mask; partially-masked bytes are handled by an internal read-modify-write (RMW) sequence.
- Adds a req/gnt handshake and an explicit read-valid output.
- Drop-in successor for the fixed 32x512 wrapper under all SoC memories (main SRAM, ROM-shadow, scratch).

Parameters:
- Width, 32, data width in bits; must be a multiple of 32 (elaboration error otherwise).
- Depth, 512, words; must be a multiple of 512 (elaboration error otherwise).
- DataBitsPerMask, 1, kept for interface compatibility; any value accepted, behaviour is bit-granular regardless.
- MemInitFile, "", unused; interface compatibility.
- Derived: Aw = $clog2(Depth), NCol = Width/32, NBank = Depth/512.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle (req_i && gnt_o).
- write_i  in  1  1 = write, 0 = read.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  per-bit write enable.
- rvalid_o  out  1  rdata_o valid this cycle.
- rdata_o  out  Width  read data; meaningful only while rvalid_o=1.
- cfg_i  in  ram_1p_cfg_t  ignored.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state <= IDLE; rvalid_o <= 0.
  - gnt_o=1 in the cycle after reset.
  - All macros deselected (csb0=1) in any cycle where rst_i=1.
  - A pending RMW write is abandoned; memory contents are unchanged by that write.
- Bank decode:
  - bank = addr_i / 512; the macro row addr0 is addr_i[8:0].
  - If addr_i >= Depth (only possible when NBank is not a power of two), no macro is selected. Writes are discarded. Reads return all-zero with normal rvalid timing.
- Byte classification, per 8-bit byte b of wmask_i:
  - full: all bits set.
  - empty: no bits set.
  - partial: anything else.
  - The write is partial if any byte is partial.
- Second macro port (csb1) tied inactive; other unused macro inputs tied to constants.
- State IDLE:
  - gnt_o=1.
  - Accepted read: selected bank's macros get csb0=0, web0=1. Next cycle rvalid_o=1 and rdata_o = selected bank's dout0, muxed by the registered bank index. Latency = 1 cycle, throughput 1/cycle.
  - Accepted non-partial write: csb0=0, web0=0, wmask0 = per-byte full flags, din0 = wdata_i. Done in one cycle; no rvalid_o. All-empty mask is accepted and changes nothing.
  - Accepted partial write: issue a read of the target address; register addr, wdata and wmask; go to RMW.
- State RMW (one cycle):
  - gnt_o=0; requests are not accepted.
  - Write to the registered address with din0 = (dout0 & ~wmask_q) | (wdata_q & wmask_q) and all four macro byte masks = 1.
  - rvalid_o=0.
  - Return to IDLE.
  - A partial write therefore costs 2 cycles.
- Read immediately after a write (including after RMW) returns the new data.
- rvalid_o falls the cycle after a read response unless another read was accepted.
- No combinational path from req_i to rvalid_o/rdata_o.

Test Plan:
- Reset then idle, Width=64, Depth=1024: rvalid_o=0 and gnt_o=1 in the first cycle after reset; no macro csb0 low.
- Write addr 0x205, wdata 0x1122334455667788, mask all-ones; read 0x205 -> one cycle later rvalid_o=1, rdata_o=0x1122334455667788; bank 1 row 5 written, bank 0 untouched.
- Partial write, Width=32: preload 0xAABBCCDD at addr 3; write wdata 0x0000000F, mask 0x0000000F -> gnt_o low for one cycle; read back returns 0xAABBCCDF.
- Back-to-back reads to addrs 0, 511, 512 on consecutive cycles -> three consecutive rvalid_o pulses with the correct data, bank mux following the registered index.
- rst_i asserted during the RMW cycle of a partial write to addr 7 (old value 0x12345678) -> read after reset returns 0x12345678; state IDLE.
- Depth=1536 (Aw=11), read addr 0x700 -> rvalid_o=1, rdata_o=0; write to 0x700 alters no macro.
